// File: rtl/pipe_pkg.sv
// Shared EX/MEM pipeline types and constants.
//   ex_ctrl_t  : control bundle arriving from EX (write enables plus control-flow type)
//   mem_ctrl_t : control bundle carried into MEM
//   PC_STEP    : instruction size, used for the JAL/JALR link value
package pipe_pkg;

    localparam int unsigned PC_STEP             = 4;
    localparam int unsigned FLUSH_DEPTH_DEFAULT = 2;

    typedef struct packed {
        logic reg_write;
        logic mem_read;
        logic mem_write;
        logic mem_to_reg;
        logic branch;
        logic jal;
        logic jalr;
    } ex_ctrl_t;

    typedef struct packed {
        logic reg_write;
        logic mem_read;
        logic mem_write;
        logic mem_to_reg;
    } mem_ctrl_t;

    typedef enum logic [0:0] {
        StIdle,
        StSquash
    } squash_state_t;

endpackage

// File: rtl/ex_mem_stage_if.sv
// EX -> MEM boundary signal bundle.
//   master : EX side, drives the instruction/control, observes MEM outputs and redirect
//   slave  : the EX/MEM stage itself
interface ex_mem_stage_if #(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned REG_ADDR_WIDTH = 5
);
    // EX side
    logic                      InValid;
    logic                      Stall;
    logic [DATA_WIDTH-1:0]     ALUResult;
    logic [DATA_WIDTH-1:0]     StoreData;
    logic [DATA_WIDTH-1:0]     PC;
    logic [DATA_WIDTH-1:0]     Imm;
    logic [REG_ADDR_WIDTH-1:0] Rd;
    logic                      RegWrite;
    logic                      MemRead;
    logic                      MemWrite;
    logic                      MemToReg;
    logic                      Branch;
    logic                      Jal;
    logic                      Jalr;

    // MEM side and redirect
    logic                      MemValid;
    logic [DATA_WIDTH-1:0]     MemResult;
    logic [DATA_WIDTH-1:0]     MemStoreData;
    logic [REG_ADDR_WIDTH-1:0] MemRd;
    logic                      MemRegWrite;
    logic                      MemMemRead;
    logic                      MemMemWrite;
    logic                      MemMemToReg;
    logic                      BrTaken;
    logic [DATA_WIDTH-1:0]     BrTarget;
    logic                      TargetMisaligned;
    logic                      Squashing;

    modport master (
        output InValid, Stall, ALUResult, StoreData, PC, Imm, Rd,
               RegWrite, MemRead, MemWrite, MemToReg, Branch, Jal, Jalr,
        input  MemValid, MemResult, MemStoreData, MemRd, MemRegWrite, MemMemRead,
               MemMemWrite, MemMemToReg, BrTaken, BrTarget, TargetMisaligned, Squashing
    );

    modport slave (
        input  InValid, Stall, ALUResult, StoreData, PC, Imm, Rd,
               RegWrite, MemRead, MemWrite, MemToReg, Branch, Jal, Jalr,
        output MemValid, MemResult, MemStoreData, MemRd, MemRegWrite, MemMemRead,
               MemMemWrite, MemMemToReg, BrTaken, BrTarget, TargetMisaligned, Squashing
    );

endinterface

// File: rtl/branch_resolve.sv
// Combinational control-flow resolution for the instruction leaving EX.
//   alu_result_i, pc_i, imm_i : EX datapath values
//   ctrl_i                    : EX control bundle
//   accept_i                  : instruction is valid and not being squashed
//   taken_o                   : redirect required
//   target_o                  : redirect address (PC+Imm, or ALUResult with bit 0 cleared for JALR)
//   link_o                    : PC + PC_STEP, the JAL/JALR writeback value
//   misaligned_o              : taken redirect to an address that is not word aligned
module branch_resolve
    import pipe_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0] alu_result_i,
    input  logic [DATA_WIDTH-1:0] pc_i,
    input  logic [DATA_WIDTH-1:0] imm_i,
    input  ex_ctrl_t              ctrl_i,
    input  logic                  accept_i,
    output logic                  taken_o,
    output logic [DATA_WIDTH-1:0] target_o,
    output logic [DATA_WIDTH-1:0] link_o,
    output logic                  misaligned_o
);

    always_comb begin
        link_o   = pc_i + DATA_WIDTH'(PC_STEP);
        target_o = ctrl_i.jalr ? {alu_result_i[DATA_WIDTH-1:1], 1'b0} : pc_i + imm_i;
        // The ALU already evaluated the branch compare; its bit 0 is the condition.
        taken_o  = accept_i & ((ctrl_i.branch & alu_result_i[0]) | ctrl_i.jal | ctrl_i.jalr);
        misaligned_o = taken_o & (target_o[1:0] != 2'b00);
    end

endmodule

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register with branch/jump resolution and wrong-path squash.
//   clk, reset : rising-edge clock, asynchronous active-high reset
//   bus        : slave side of ex_mem_stage_if (EX inputs, MEM outputs, redirect, Squashing)
// A taken redirect pulses BrTaken for one cycle and squashes the next FLUSH_DEPTH
// non-stalled cycles of incoming instructions. Stall freezes everything and suppresses
// the redirect pulse.
module ex_mem_stage
    import pipe_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned REG_ADDR_WIDTH = 5,
    parameter int unsigned FLUSH_DEPTH    = FLUSH_DEPTH_DEFAULT
) (
    input logic           clk,
    input logic           reset,
    ex_mem_stage_if.slave bus
);

    localparam int unsigned CntW = 3;

    ex_ctrl_t              ex_ctrl;
    logic                  accept;
    logic                  taken;
    logic [DATA_WIDTH-1:0] target;
    logic [DATA_WIDTH-1:0] link;
    logic                  misaligned;

    squash_state_t         state_q, state_d;
    logic [CntW-1:0]       squash_cnt_q, squash_cnt_d;

    logic                      valid_q;
    logic [DATA_WIDTH-1:0]     result_q;
    logic [DATA_WIDTH-1:0]     store_q;
    logic [REG_ADDR_WIDTH-1:0] rd_q;
    mem_ctrl_t                 mem_ctrl_q;
    logic                      br_taken_q;
    logic [DATA_WIDTH-1:0]     br_target_q;
    logic                      misaligned_q;

    assign ex_ctrl = '{
        reg_write:  bus.RegWrite,
        mem_read:   bus.MemRead,
        mem_write:  bus.MemWrite,
        mem_to_reg: bus.MemToReg,
        branch:     bus.Branch,
        jal:        bus.Jal,
        jalr:       bus.Jalr
    };

    assign accept = bus.InValid & (squash_cnt_q == '0);

    branch_resolve #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_branch_resolve (
        .alu_result_i (bus.ALUResult),
        .pc_i         (bus.PC),
        .imm_i        (bus.Imm),
        .ctrl_i       (ex_ctrl),
        .accept_i     (accept),
        .taken_o      (taken),
        .target_o     (target),
        .link_o       (link),
        .misaligned_o (misaligned)
    );

    // Squash FSM. A taken instruction can only arrive in StIdle since accept is low
    // whenever the counter is nonzero, so a redirect is never re-armed mid-squash.
    always_comb begin
        state_d      = state_q;
        squash_cnt_d = squash_cnt_q;
        if (!bus.Stall) begin
            unique case (state_q)
                StIdle: begin
                    if (taken) begin
                        state_d      = StSquash;
                        squash_cnt_d = CntW'(FLUSH_DEPTH);
                    end
                end
                StSquash: begin
                    squash_cnt_d = squash_cnt_q - CntW'(1);
                    if (squash_cnt_q == CntW'(1)) begin
                        state_d = StIdle;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= StIdle;
            squash_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            squash_cnt_q <= squash_cnt_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q      <= 1'b0;
            result_q     <= '0;
            store_q      <= '0;
            rd_q         <= '0;
            mem_ctrl_q   <= '0;
            br_taken_q   <= 1'b0;
            br_target_q  <= '0;
            misaligned_q <= 1'b0;
        end else if (bus.Stall) begin
            // Contents hold, but the redirect must not re-fire while frozen.
            br_taken_q   <= 1'b0;
            misaligned_q <= 1'b0;
        end else begin
            valid_q               <= accept;
            result_q              <= (ex_ctrl.jal | ex_ctrl.jalr) ? link : bus.ALUResult;
            store_q               <= bus.StoreData;
            rd_q                  <= bus.Rd;
            mem_ctrl_q.reg_write  <= ex_ctrl.reg_write & accept;
            mem_ctrl_q.mem_read   <= ex_ctrl.mem_read & accept;
            mem_ctrl_q.mem_write  <= ex_ctrl.mem_write & accept;
            mem_ctrl_q.mem_to_reg <= ex_ctrl.mem_to_reg;
            br_taken_q            <= taken;
            misaligned_q          <= misaligned;
            if (taken) begin
                br_target_q <= target;
            end
        end
    end

    assign bus.MemValid         = valid_q;
    assign bus.MemResult        = result_q;
    assign bus.MemStoreData     = store_q;
    assign bus.MemRd            = rd_q;
    assign bus.MemRegWrite      = mem_ctrl_q.reg_write;
    assign bus.MemMemRead       = mem_ctrl_q.mem_read;
    assign bus.MemMemWrite      = mem_ctrl_q.mem_write;
    assign bus.MemMemToReg      = mem_ctrl_q.mem_to_reg;
    assign bus.BrTaken          = br_taken_q;
    assign bus.BrTarget         = br_target_q;
    assign bus.TargetMisaligned = misaligned_q;
    assign bus.Squashing        = (squash_cnt_q != '0);

endmodule

// File: tb/tb_ex_mem_stage.sv
// Self-checking bench for ex_mem_stage: directed scenarios with literal expectations,
// then randomized traffic, all compared every cycle against a behavioural model.
module tb_ex_mem_stage;

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 5;
    localparam int unsigned FD = 2;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    ex_mem_stage_if #(.DATA_WIDTH(DW), .REG_ADDR_WIDTH(AW)) bus ();

    ex_mem_stage #(
        .DATA_WIDTH     (DW),
        .REG_ADDR_WIDTH (AW),
        .FLUSH_DEPTH    (FD)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int tests = 0;
    int fails = 0;

    // Behavioural model of the visible MEM-side state.
    logic          m_valid, m_rw, m_mr, m_mw, m_m2r, m_taken, m_mis;
    logic [DW-1:0] m_result, m_store, m_target;
    logic [AW-1:0] m_rd;
    int            m_cnt;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        m_valid = 0; m_rw = 0; m_mr = 0; m_mw = 0; m_m2r = 0; m_taken = 0; m_mis = 0;
        m_result = '0; m_store = '0; m_target = '0; m_rd = '0; m_cnt = 0;
    endtask

    // One rising edge of the stage, described by its rules rather than its registers.
    task automatic model_clock();
        logic          acc, tk;
        logic [DW-1:0] tgt;
        if (bus.Stall) begin
            m_taken = 0;
            m_mis   = 0;
        end else begin
            acc = bus.InValid && (m_cnt == 0);
            tk  = acc && ((bus.Branch && bus.ALUResult[0]) || bus.Jal || bus.Jalr);
            tgt = bus.Jalr ? ((bus.ALUResult >> 1) << 1) : bus.PC + bus.Imm;
            m_valid  = acc;
            m_result = (bus.Jal || bus.Jalr) ? bus.PC + 32'd4 : bus.ALUResult;
            m_store  = bus.StoreData;
            m_rd     = bus.Rd;
            m_rw     = bus.RegWrite && acc;
            m_mr     = bus.MemRead && acc;
            m_mw     = bus.MemWrite && acc;
            m_m2r    = bus.MemToReg;
            m_taken  = tk;
            m_mis    = tk && (tgt % 4 != 0);
            if (tk) m_target = tgt;
            if (tk) m_cnt = FD;
            else if (m_cnt > 0) m_cnt = m_cnt - 1;
        end
    endtask

    task automatic compare_all();
        chk("MemValid",         bus.MemValid,         m_valid);
        chk("MemResult",        bus.MemResult,        m_result);
        chk("MemStoreData",     bus.MemStoreData,     m_store);
        chk("MemRd",            bus.MemRd,            m_rd);
        chk("MemRegWrite",      bus.MemRegWrite,      m_rw);
        chk("MemMemRead",       bus.MemMemRead,       m_mr);
        chk("MemMemWrite",      bus.MemMemWrite,      m_mw);
        chk("MemMemToReg",      bus.MemMemToReg,      m_m2r);
        chk("BrTaken",          bus.BrTaken,          m_taken);
        chk("BrTarget",         bus.BrTarget,         m_target);
        chk("TargetMisaligned", bus.TargetMisaligned, m_mis);
        chk("Squashing",        bus.Squashing,        m_cnt != 0);
    endtask

    task automatic cycle();
        @(posedge clk);
        model_clock();
        #1;
        compare_all();
    endtask

    task automatic clear_in();
        bus.InValid = 0; bus.Stall = 0; bus.ALUResult = '0; bus.StoreData = '0;
        bus.PC = '0; bus.Imm = '0; bus.Rd = '0; bus.RegWrite = 0; bus.MemRead = 0;
        bus.MemWrite = 0; bus.MemToReg = 0; bus.Branch = 0; bus.Jal = 0; bus.Jalr = 0;
    endtask

    task automatic taken_beq(input logic [DW-1:0] pc, input logic [DW-1:0] imm);
        clear_in();
        bus.InValid = 1; bus.Branch = 1; bus.ALUResult = 32'd1; bus.PC = pc; bus.Imm = imm;
    endtask

    initial begin
        reset = 1'b1;
        clear_in();
        model_reset();
        #3;
        compare_all();
        chk("reset_MemValid", bus.MemValid, 0);
        chk("reset_Squashing", bus.Squashing, 0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        // ALU-op passthrough
        clear_in();
        bus.InValid = 1; bus.ALUResult = 32'h0000_1234; bus.RegWrite = 1; bus.Rd = 5;
        cycle();
        chk("pass_MemValid", bus.MemValid, 1);
        chk("pass_MemResult", bus.MemResult, 32'h1234);
        chk("pass_MemRd", bus.MemRd, 5);
        chk("pass_MemRegWrite", bus.MemRegWrite, 1);
        chk("pass_BrTaken", bus.BrTaken, 0);

        // Taken BEQ, then two squashed ALU ops
        taken_beq(32'h100, 32'h20);
        cycle();
        chk("beq_BrTaken", bus.BrTaken, 1);
        chk("beq_BrTarget", bus.BrTarget, 32'h120);
        chk("beq_Squashing0", bus.Squashing, 1);
        clear_in();
        bus.InValid = 1; bus.RegWrite = 1;
        cycle();
        chk("beq_sq1_MemValid", bus.MemValid, 0);
        chk("beq_sq1_MemRegWrite", bus.MemRegWrite, 0);
        chk("beq_sq1_Squashing", bus.Squashing, 1);
        cycle();
        chk("beq_sq2_MemValid", bus.MemValid, 0);
        chk("beq_sq2_Squashing", bus.Squashing, 0);

        // JALR misaligned target with link
        clear_in();
        bus.InValid = 1; bus.Jalr = 1; bus.ALUResult = 32'h203; bus.PC = 32'h40;
        bus.Rd = 1; bus.RegWrite = 1;
        cycle();
        chk("jalr_BrTarget", bus.BrTarget, 32'h202);
        chk("jalr_Misaligned", bus.TargetMisaligned, 1);
        chk("jalr_MemResult", bus.MemResult, 32'h44);
        chk("jalr_MemRegWrite", bus.MemRegWrite, 1);
        clear_in();
        repeat (2) cycle();

        // Stall during squash
        taken_beq(32'h200, 32'h8);
        cycle();
        chk("stl_BrTaken", bus.BrTaken, 1);
        clear_in();
        bus.Stall = 1; bus.InValid = 1; bus.RegWrite = 1;
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("stl_BrTaken_held", bus.BrTaken, 0);
            chk("stl_Squashing", bus.Squashing, 1);
            chk("stl_MemValid", bus.MemValid, 1);
            chk("stl_BrTarget", bus.BrTarget, 32'h208);
        end
        bus.Stall = 0;
        cycle();
        chk("stl_after1_Squashing", bus.Squashing, 1);
        cycle();
        chk("stl_after2_Squashing", bus.Squashing, 0);

        // Taken JAL followed by taken BNE inside the squash window
        clear_in();
        bus.InValid = 1; bus.Jal = 1; bus.PC = 32'h300; bus.Imm = 32'h10; bus.RegWrite = 1;
        cycle();
        chk("jal_BrTaken", bus.BrTaken, 1);
        chk("jal_BrTarget", bus.BrTarget, 32'h310);
        chk("jal_MemResult", bus.MemResult, 32'h304);
        taken_beq(32'h400, 32'h4);
        cycle();
        chk("bne_BrTaken", bus.BrTaken, 0);
        chk("bne_MemValid", bus.MemValid, 0);
        chk("bne_BrTarget", bus.BrTarget, 32'h310);
        clear_in();
        cycle();
        chk("bne_Squashing_end", bus.Squashing, 0);

        // Async reset mid-squash
        taken_beq(32'h500, 32'h40);
        cycle();
        clear_in();
        cycle();
        chk("rst_pre_Squashing", bus.Squashing, 1);
        reset = 1'b1;
        #1;
        model_reset();
        compare_all();
        chk("rst_async_Squashing", bus.Squashing, 0);
        chk("rst_async_BrTarget", bus.BrTarget, 0);
        #2;
        reset = 1'b0;
        bus.InValid = 1; bus.RegWrite = 1; bus.ALUResult = 32'h55; bus.Rd = 3;
        cycle();
        chk("rst_after_MemValid", bus.MemValid, 1);
        chk("rst_after_MemRegWrite", bus.MemRegWrite, 1);

        // Randomized traffic
        for (int n = 0; n < 600; n++) begin
            int kind;
            clear_in();
            kind          = int'($urandom_range(0, 3));
            bus.Stall     = ($urandom_range(0, 3) == 0);
            bus.InValid   = ($urandom_range(0, 4) != 0);
            bus.ALUResult = $urandom;
            bus.StoreData = $urandom;
            bus.PC        = $urandom;
            bus.Imm       = ($urandom_range(0, 1) == 0) ? $urandom : 32'($urandom_range(0, 63));
            bus.Rd        = AW'($urandom);
            bus.RegWrite  = $urandom_range(0, 1);
            bus.MemRead   = $urandom_range(0, 1);
            bus.MemWrite  = $urandom_range(0, 1);
            bus.MemToReg  = $urandom_range(0, 1);
            bus.Branch    = (kind == 1);
            bus.Jal       = (kind == 2);
            bus.Jalr      = (kind == 3);
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ex_mem_stage.md
Name: ex_mem_stage

Overview:
- EX/MEM pipeline boundary placed directly downstream of the ALU.
- Registers ALUResult and the EX-stage control and data into the MEM stage.
- Resolves conditional branches from ALUResult[0] and resolves JAL/JALR.
- Issues a one-cycle redirect (BrTaken/BrTarget) and squashes the next FLUSH_DEPTH wrong-path cycles entering the stage.

Parameters:
DATA_WIDTH, 32, datapath width
REG_ADDR_WIDTH, 5, register index width
FLUSH_DEPTH, 2, cycles squashed after a taken redirect (1..7)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high
InValid  in  1  EX holds a valid instruction
Stall  in  1  hold stage contents (memory busy / hazard)
ALUResult  in  DATA_WIDTH  ALU output
StoreData  in  DATA_WIDTH  rs2 value for stores
PC  in  DATA_WIDTH  PC of EX instruction
Imm  in  DATA_WIDTH  sign-extended immediate
Rd  in  REG_ADDR_WIDTH  destination register
RegWrite, MemRead, MemWrite, MemToReg  in  1 each  EX control
Branch, Jal, Jalr  in  1 each  control-flow type
MemValid  out  1  MEM holds valid instruction
MemResult  out  DATA_WIDTH  ALUResult, or PC+4 for Jal/Jalr
MemStoreData  out  DATA_WIDTH  registered StoreData
MemRd  out  REG_ADDR_WIDTH  registered Rd
MemRegWrite, MemMemRead, MemMemWrite, MemMemToReg  out  1 each  gated control
BrTaken  out  1  one-cycle redirect pulse
BrTarget  out  DATA_WIDTH  redirect address
TargetMisaligned  out  1  pulse with BrTaken when BrTarget[1:0]!=0
Squashing  out  1  high while squash counter nonzero

Behaviour:
- Reset (asynchronous, any time): all outputs 0, squash counter 0, state IDLE. A reset mid-squash abandons the squash.
- Latency is 1 cycle: an instruction presented on cycle N appears on the Mem* outputs on cycle N+1.
- Stall=1 has priority over everything:
  - all registers hold;
  - the squash counter holds;
  - BrTaken and TargetMisaligned are forced to 0 (no re-pulse while stalled).
- Capture (Stall=0):
  - `accept = InValid & (SquashCnt==0)`.
  - MemValid <= accept.
  - Write enables (RegWrite, MemRead, MemWrite) are ANDed with accept. A bubble never writes.
  - Datapath fields are captured unconditionally.
- Taken condition: `Taken = accept & ((Branch & ALUResult[0]) | Jal | Jalr)`. The ALU is already set to the BEQ/BNE/BGE/BLT opcode, so bit 0 is the condition.
- Target computation (DATA_WIDTH arithmetic, wrap-around modulo 2^DATA_WIDTH):
  - Branch/Jal: PC + Imm.
  - Jalr: ALUResult & ~1.
- Link value: MemResult = PC + 4 for Jal/Jalr, else ALUResult.
- BrTaken <= Taken and BrTarget <= target, registered, so both are valid in the same cycle the instruction appears in MEM. When not taken, BrTaken=0 and BrTarget holds its previous value.
- TargetMisaligned <= Taken & (target[1:0] != 0). BrTaken still fires.
- State machine:
  - IDLE --Taken & !Stall--> SQUASH, with SquashCnt <= FLUSH_DEPTH.
  - SQUASH: each non-stalled cycle, SquashCnt decrements and the incoming instruction is captured as a bubble.
  - SQUASH --SquashCnt==1 & !Stall--> IDLE.
  - Squashing = (SquashCnt != 0).
- A taken branch arriving while SQUASH is itself squashed: no redirect, counter not reloaded.
- Back-to-back taken instructions are therefore impossible; the second one is always squashed.
- Branch with ALUResult[0]=0: not taken, no squash, and the instruction is still valid in MEM with no writes (control carried from EX).

Decomposition:
- Shared package `pipe_pkg`:
  - typedef `ex_ctrl_t` (RegWrite, MemRead, MemWrite, MemToReg, Branch, Jal, Jalr);
  - typedef `mem_ctrl_t`;
  - constant PC_STEP = 4;
  - FLUSH_DEPTH default.
- One combinational sub-module `branch_resolve`: computes Taken, target, link and misalign from the ALU/PC/Imm/control inputs.
- ex_mem_stage holds the registers and the squash FSM.

Test Plan:
- ALU-op passthrough: InValid=1, ALUResult=0x0000_1234, RegWrite=1, Rd=5 -> next cycle MemValid=1, MemResult=0x1234, MemRd=5, MemRegWrite=1, BrTaken=0.
- Taken BEQ: PC=0x100, Imm=0x20, Branch=1, ALUResult=1 -> next cycle BrTaken=1, BrTarget=0x120. The following 2 cycles with InValid=1, RegWrite=1 give MemValid=0, MemRegWrite=0, Squashing=1,1, then 0.
- JALR misaligned/link: Jalr=1, ALUResult=0x203, PC=0x40, Rd=1 -> BrTarget=0x202, TargetMisaligned=1, MemResult=0x44, MemRegWrite=1.
- Stall during squash: taken branch, then Stall=1 for 3 cycles -> outputs and SquashCnt frozen, BrTaken stays 0 after the first pulse, squash completes 2 unstalled cycles later.
- Branch inside squash window: taken JAL followed by taken BNE (ALUResult=1) -> only one BrTaken pulse, BNE arrives with MemValid=0, Squashing ends after 2 unstalled cycles.
- Async reset mid-squash: reset asserted between clock edges with SquashCnt=1 -> all outputs 0 immediately. After release, InValid=1 with RegWrite=1 is accepted on the first edge.
